// File: rtl/sy_pkg.sv
// Shared types for the dcache miss path: MSHR entry states, TileLink grow
// params and the per-entry record as laid out in the default configuration.
package sy_pkg;

   typedef enum logic [2:0] {
      MSHR_IDLE,
      MSHR_ACQ,
      MSHR_GNT,
      MSHR_ACK,
      MSHR_REFILL
   } mshr_state_e;

   localparam logic [2:0] TL_NTOB = 3'd0;
   localparam logic [2:0] TL_NTOT = 3'd1;
   localparam logic [2:0] TL_BTOT = 3'd2;

   localparam int MSHR_ADDR_WTH   = 64;
   localparam int MSHR_LINE_BYTES = 64;
   localparam int MSHR_BEAT_BYTES = 8;
   localparam int MSHR_SINK_WTH   = 4;

   typedef struct packed {
      logic [MSHR_ADDR_WTH-1:0]                          addr;
      logic [2:0]                                        perm;
      logic [MSHR_SINK_WTH-1:0]                          sink;
      logic [$clog2(MSHR_LINE_BYTES/MSHR_BEAT_BYTES)-1:0] beat_cnt;
      logic [MSHR_LINE_BYTES*8-1:0]                      line;
   } mshr_entry_t;

   // True when the grow param ends in Trunk (write) permission.
   function automatic logic perm_needs_t(input logic [2:0] perm);
      return (perm == TL_NTOT) || (perm == TL_BTOT);
   endfunction

endpackage

// File: rtl/sy_dcache_mshr_entry.sv
// One miss-status holding register: lifecycle FSM, beat counter and line buffer.
// state  | meaning
// IDLE   | free, allocatable
// ACQ    | AcquireBlock pending on A
// GNT    | collecting GrantData beats
// ACK    | GrantAck pending on E
// REFILL | assembled line offered to the controller
module sy_dcache_mshr_entry
   import sy_pkg::*;
#(
   parameter int ADDR_WTH   = 64,
   parameter int LINE_BYTES = 64,
   parameter int BEAT_BYTES = 8,
   parameter int SINK_WTH   = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    alloc_i,
   input  logic [ADDR_WTH-1:0]     alloc_addr_i,
   input  logic [2:0]              alloc_perm_i,
   input  logic                    acq_fire_i,
   input  logic                    beat_valid_i,
   input  logic [SINK_WTH-1:0]     beat_sink_i,
   input  logic [BEAT_BYTES*8-1:0] beat_data_i,
   input  logic                    ack_fire_i,
   input  logic                    refill_fire_i,
   output mshr_state_e             state_o,
   output logic [ADDR_WTH-1:0]     addr_o,
   output logic [2:0]              perm_o,
   output logic [SINK_WTH-1:0]     sink_o,
   output logic [LINE_BYTES*8-1:0] line_o
);
   localparam int BEATS   = LINE_BYTES / BEAT_BYTES;
   localparam int BEAT_W  = BEAT_BYTES * 8;
   localparam int CNT_WTH = (BEATS > 1) ? $clog2(BEATS) : 1;

   mshr_state_e             r_state;
   mshr_state_e             w_state_nxt;
   logic [CNT_WTH-1:0]      r_cnt;
   logic [ADDR_WTH-1:0]     r_addr;
   logic [2:0]              r_perm;
   logic [SINK_WTH-1:0]     r_sink;
   logic [LINE_BYTES*8-1:0] r_line;
   logic                    w_beat;
   logic                    w_last;

   assign w_beat = beat_valid_i && (r_state == MSHR_GNT);
   assign w_last = (r_cnt == CNT_WTH'(BEATS - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= MSHR_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         MSHR_IDLE:   if (alloc_i)           w_state_nxt = MSHR_ACQ;
         MSHR_ACQ:    if (acq_fire_i)        w_state_nxt = MSHR_GNT;
         MSHR_GNT:    if (w_beat && w_last)  w_state_nxt = MSHR_ACK;
         MSHR_ACK:    if (ack_fire_i)        w_state_nxt = MSHR_REFILL;
         MSHR_REFILL: if (refill_fire_i)     w_state_nxt = MSHR_IDLE;
         default:                            w_state_nxt = MSHR_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_addr <= '0;
         r_perm <= '0;
         r_sink <= '0;
         r_cnt  <= '0;
         r_line <= '0;
      end else begin
         if (alloc_i && (r_state == MSHR_IDLE)) begin
            r_addr <= alloc_addr_i;
            r_perm <= alloc_perm_i;
            r_cnt  <= '0;
         end
         if (w_beat) begin
            r_line[r_cnt*BEAT_W +: BEAT_W] <= beat_data_i;
            r_cnt <= w_last ? '0 : r_cnt + CNT_WTH'(1);
            if (r_cnt == '0) r_sink <= beat_sink_i;
         end
      end
   end

   assign state_o = r_state;
   assign addr_o  = r_addr;
   assign perm_o  = r_perm;
   assign sink_o  = r_sink;
   assign line_o  = r_line;

endmodule

// File: rtl/sy_dcache_mshr_file.sv
// Non-blocking MSHR file: line match/merge and allocation, round-robin A issue,
// D beat routing by source, fixed-priority E and refill return.
module sy_dcache_mshr_file
   import sy_pkg::*;
#(
   parameter int NUM_MSHR   = 4,
   parameter int ADDR_WTH   = 64,
   parameter int LINE_BYTES = 64,
   parameter int BEAT_BYTES = 8,
   parameter int SRC_BASE   = 0,
   parameter int SRC_WTH    = 4,
   parameter int SINK_WTH   = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        miss_req_i,
   input  logic [ADDR_WTH-1:0]         miss_addr_i,
   input  logic [2:0]                  miss_perm_i,
   output logic                        miss_ack_o,
   output logic [$clog2(NUM_MSHR)-1:0] miss_id_o,
   output logic                        miss_merge_o,
   output logic                        full_o,
   output logic                        acq_valid_o,
   input  logic                        acq_ready_i,
   output logic [ADDR_WTH-1:0]         acq_addr_o,
   output logic [2:0]                  acq_perm_o,
   output logic [SRC_WTH-1:0]          acq_source_o,
   input  logic                        gnt_valid_i,
   output logic                        gnt_ready_o,
   input  logic [SRC_WTH-1:0]          gnt_source_i,
   input  logic [SINK_WTH-1:0]         gnt_sink_i,
   input  logic [BEAT_BYTES*8-1:0]     gnt_data_i,
   output logic                        ack_valid_o,
   input  logic                        ack_ready_i,
   output logic [SINK_WTH-1:0]         ack_sink_o,
   output logic                        refill_valid_o,
   input  logic                        refill_ready_i,
   output logic [$clog2(NUM_MSHR)-1:0] refill_id_o,
   output logic [ADDR_WTH-1:0]         refill_addr_o,
   output logic [LINE_BYTES*8-1:0]     refill_data_o
);
   localparam int ID_WTH = $clog2(NUM_MSHR);
   localparam int OFF    = $clog2(LINE_BYTES);
   localparam int LINE_W = LINE_BYTES * 8;

   mshr_state_e         w_state [NUM_MSHR];
   logic [ADDR_WTH-1:0] w_addr  [NUM_MSHR];
   logic [2:0]          w_perm  [NUM_MSHR];
   logic [SINK_WTH-1:0] w_sink  [NUM_MSHR];
   logic [LINE_W-1:0]   w_line  [NUM_MSHR];

   logic [ADDR_WTH-1:0] w_req_line;
   logic                w_unused_off;
   logic                w_hit, w_perm_ok, w_free, w_alloc;
   logic [ID_WTH-1:0]   w_hit_idx, w_free_idx;
   logic                w_src_ok;
   logic [ID_WTH-1:0]   w_gnt_idx;

   logic [ID_WTH-1:0]   r_rr_ptr, r_acq_idx, r_ack_idx, r_ref_idx;
   logic                r_acq_lock, r_ack_lock, r_ref_lock;
   logic                w_rr_found, w_ack_found, w_ref_found;
   logic [ID_WTH-1:0]   w_rr_idx, w_ack_pick, w_ref_pick;
   logic [ID_WTH-1:0]   w_acq_idx, w_ack_idx, w_ref_idx;
   logic                w_acq_fire, w_ack_fire, w_ref_fire;

   assign w_req_line   = {miss_addr_i[ADDR_WTH-1:OFF], {OFF{1'b0}}};
   assign w_unused_off = ^miss_addr_i[OFF-1:0];

   always_comb begin
      w_hit      = 1'b0;
      w_hit_idx  = '0;
      w_perm_ok  = 1'b0;
      w_free     = 1'b0;
      w_free_idx = '0;
      for (int i = 0; i < NUM_MSHR; i++) begin
         if ((w_state[i] != MSHR_IDLE) && (w_addr[i] == w_req_line)) begin
            w_hit     = 1'b1;
            w_hit_idx = ID_WTH'(i);
            w_perm_ok = !(perm_needs_t(miss_perm_i) && !perm_needs_t(w_perm[i]));
         end
      end
      for (int i = NUM_MSHR - 1; i >= 0; i--) begin
         if (w_state[i] == MSHR_IDLE) begin
            w_free     = 1'b1;
            w_free_idx = ID_WTH'(i);
         end
      end
   end

   // A line already in flight never gets a second entry, even when the merge is refused.
   assign w_alloc      = miss_req_i && !w_hit && w_free;
   assign miss_ack_o   = miss_req_i && (w_hit ? w_perm_ok : w_free);
   assign miss_merge_o = miss_req_i && w_hit && w_perm_ok;
   assign miss_id_o    = !miss_ack_o ? '0 : (w_hit ? w_hit_idx : w_free_idx);
   assign full_o       = !w_free;

   assign w_src_ok  = (32'(gnt_source_i) >= SRC_BASE) && (32'(gnt_source_i) < SRC_BASE + NUM_MSHR);
   assign w_gnt_idx = ID_WTH'(32'(gnt_source_i) - SRC_BASE);
   assign gnt_ready_o = 1'b1;

   always_comb begin
      w_rr_found  = 1'b0;
      w_rr_idx    = r_rr_ptr;
      w_ack_found = 1'b0;
      w_ack_pick  = '0;
      w_ref_found = 1'b0;
      w_ref_pick  = '0;
      for (int k = NUM_MSHR - 1; k >= 0; k--) begin
         if (w_state[ID_WTH'(r_rr_ptr + ID_WTH'(k))] == MSHR_ACQ) begin
            w_rr_found = 1'b1;
            w_rr_idx   = ID_WTH'(r_rr_ptr + ID_WTH'(k));
         end
         if (w_state[k] == MSHR_ACK) begin
            w_ack_found = 1'b1;
            w_ack_pick  = ID_WTH'(k);
         end
         if (w_state[k] == MSHR_REFILL) begin
            w_ref_found = 1'b1;
            w_ref_pick  = ID_WTH'(k);
         end
      end
   end

   // A stalled winner is locked so a newly eligible entry cannot swap the payload.
   assign w_acq_idx = r_acq_lock ? r_acq_idx : w_rr_idx;
   assign w_ack_idx = r_ack_lock ? r_ack_idx : w_ack_pick;
   assign w_ref_idx = r_ref_lock ? r_ref_idx : w_ref_pick;

   assign acq_valid_o    = r_acq_lock || w_rr_found;
   assign ack_valid_o    = r_ack_lock || w_ack_found;
   assign refill_valid_o = r_ref_lock || w_ref_found;
   assign w_acq_fire     = acq_valid_o && acq_ready_i;
   assign w_ack_fire     = ack_valid_o && ack_ready_i;
   assign w_ref_fire     = refill_valid_o && refill_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr_ptr   <= '0;
         r_acq_lock <= 1'b0;
         r_acq_idx  <= '0;
         r_ack_lock <= 1'b0;
         r_ack_idx  <= '0;
         r_ref_lock <= 1'b0;
         r_ref_idx  <= '0;
      end else begin
         if (w_acq_fire) r_rr_ptr <= w_acq_idx + ID_WTH'(1);
         r_acq_lock <= acq_valid_o && !acq_ready_i;
         r_acq_idx  <= w_acq_idx;
         r_ack_lock <= ack_valid_o && !ack_ready_i;
         r_ack_idx  <= w_ack_idx;
         r_ref_lock <= refill_valid_o && !refill_ready_i;
         r_ref_idx  <= w_ref_idx;
      end
   end

   assign acq_addr_o    = acq_valid_o ? w_addr[w_acq_idx] : '0;
   assign acq_perm_o    = acq_valid_o ? w_perm[w_acq_idx] : '0;
   assign acq_source_o  = acq_valid_o ? SRC_WTH'(SRC_BASE + 32'(w_acq_idx)) : '0;
   assign ack_sink_o    = ack_valid_o ? w_sink[w_ack_idx] : '0;
   assign refill_id_o   = refill_valid_o ? w_ref_idx : '0;
   assign refill_addr_o = refill_valid_o ? w_addr[w_ref_idx] : '0;
   assign refill_data_o = refill_valid_o ? w_line[w_ref_idx] : '0;

   for (genvar g = 0; g < NUM_MSHR; g++) begin : g_entry
      sy_dcache_mshr_entry #(
         .ADDR_WTH   (ADDR_WTH),
         .LINE_BYTES (LINE_BYTES),
         .BEAT_BYTES (BEAT_BYTES),
         .SINK_WTH   (SINK_WTH)
      ) u_entry (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .alloc_i       (w_alloc && (w_free_idx == ID_WTH'(g))),
         .alloc_addr_i  (w_req_line),
         .alloc_perm_i  (miss_perm_i),
         .acq_fire_i    (w_acq_fire && (w_acq_idx == ID_WTH'(g))),
         .beat_valid_i  (gnt_valid_i && w_src_ok && (w_gnt_idx == ID_WTH'(g))),
         .beat_sink_i   (gnt_sink_i),
         .beat_data_i   (gnt_data_i),
         .ack_fire_i    (w_ack_fire && (w_ack_idx == ID_WTH'(g))),
         .refill_fire_i (w_ref_fire && (w_ref_idx == ID_WTH'(g))),
         .state_o       (w_state[g]),
         .addr_o        (w_addr[g]),
         .perm_o        (w_perm[g]),
         .sink_o        (w_sink[g]),
         .line_o        (w_line[g])
      );
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && gnt_valid_i)
         assert (w_src_ok && (w_state[w_gnt_idx] == MSHR_GNT));
   end

endmodule

// File: tb/tb_sy_dcache_mshr_file.sv
// Directed bench for the MSHR file: allocation, merge, full, interleaved grants,
// back-pressure stability and mid-transaction reset.
module tb_sy_dcache_mshr_file;
   localparam logic [2:0] NTOB = 3'd0;
   localparam logic [2:0] NTOT = 3'd1;

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic         miss_req_i = 1'b0;
   logic [63:0]  miss_addr_i = '0;
   logic [2:0]   miss_perm_i = '0;
   logic         miss_ack_o, miss_merge_o, full_o;
   logic [1:0]   miss_id_o;
   logic         acq_valid_o;
   logic         acq_ready_i = 1'b0;
   logic [63:0]  acq_addr_o;
   logic [2:0]   acq_perm_o;
   logic [3:0]   acq_source_o;
   logic         gnt_valid_i = 1'b0;
   logic         gnt_ready_o;
   logic [3:0]   gnt_source_i = '0;
   logic [3:0]   gnt_sink_i = '0;
   logic [63:0]  gnt_data_i = '0;
   logic         ack_valid_o;
   logic         ack_ready_i = 1'b0;
   logic [3:0]   ack_sink_o;
   logic         refill_valid_o;
   logic         refill_ready_i = 1'b0;
   logic [1:0]   refill_id_o;
   logic [63:0]  refill_addr_o;
   logic [511:0] refill_data_o;

   int vec_cnt = 0;
   int err_cnt = 0;

   sy_dcache_mshr_file dut (
      .clk_i(clk), .rst_i(rst_i),
      .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i), .miss_perm_i(miss_perm_i),
      .miss_ack_o(miss_ack_o), .miss_id_o(miss_id_o), .miss_merge_o(miss_merge_o), .full_o(full_o),
      .acq_valid_o(acq_valid_o), .acq_ready_i(acq_ready_i), .acq_addr_o(acq_addr_o),
      .acq_perm_o(acq_perm_o), .acq_source_o(acq_source_o),
      .gnt_valid_i(gnt_valid_i), .gnt_ready_o(gnt_ready_o), .gnt_source_i(gnt_source_i),
      .gnt_sink_i(gnt_sink_i), .gnt_data_i(gnt_data_i),
      .ack_valid_o(ack_valid_o), .ack_ready_i(ack_ready_i), .ack_sink_o(ack_sink_o),
      .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i), .refill_id_o(refill_id_o),
      .refill_addr_o(refill_addr_o), .refill_data_o(refill_data_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] beat_of(input int tag, input int k);
      return {8'(tag), 8'(k), 48'hA5A5_5A5A_0F0F};
   endfunction

   task automatic req(input logic [63:0] a, input logic [2:0] p,
                      output logic ack, output logic [1:0] id, output logic mg);
      miss_req_i  = 1'b1;
      miss_addr_i = a;
      miss_perm_i = p;
      #1;
      ack = miss_ack_o;
      id  = miss_id_o;
      mg  = miss_merge_o;
      tick();
      miss_req_i = 1'b0;
   endtask

   task automatic send_beat(input logic [3:0] src, input logic [3:0] sink, input logic [63:0] d);
      gnt_valid_i  = 1'b1;
      gnt_source_i = src;
      gnt_sink_i   = sink;
      gnt_data_i   = d;
      tick();
      gnt_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      vec_cnt++; if (acq_valid_o !== 1'b0) begin err_cnt++; $display("FAIL rst_acq_valid got %b exp 0", acq_valid_o); end
      vec_cnt++; if (ack_valid_o !== 1'b0) begin err_cnt++; $display("FAIL rst_ack_valid got %b exp 0", ack_valid_o); end
      vec_cnt++; if (refill_valid_o !== 1'b0) begin err_cnt++; $display("FAIL rst_refill_valid got %b exp 0", refill_valid_o); end
      vec_cnt++; if (full_o !== 1'b0) begin err_cnt++; $display("FAIL rst_full got %b exp 0", full_o); end
      vec_cnt++; if (miss_ack_o !== 1'b0) begin err_cnt++; $display("FAIL rst_miss_ack got %b exp 0", miss_ack_o); end
      vec_cnt++; if (refill_data_o !== '0) begin err_cnt++; $display("FAIL rst_refill_data got %h exp 0", refill_data_o); end
      vec_cnt++; if (gnt_ready_o !== 1'b1) begin err_cnt++; $display("FAIL rst_gnt_ready got %b exp 1", gnt_ready_o); end
   endtask

   task automatic test_single_miss();
      logic ack, mg;
      logic [1:0] id;
      logic [511:0] exp_line;
      exp_line = '0;
      req(64'h1000, NTOT, ack, id, mg);
      vec_cnt++; if ({ack, id, mg} !== {1'b1, 2'd0, 1'b0}) begin err_cnt++; $display("FAIL single_req ack/id/merge got %b/%0d/%b exp 1/0/0", ack, id, mg); end
      vec_cnt++; if (acq_valid_o !== 1'b1 || acq_addr_o !== 64'h1000) begin err_cnt++; $display("FAIL single_acq valid/addr got %b/%h exp 1/1000", acq_valid_o, acq_addr_o); end
      vec_cnt++; if (acq_source_o !== 4'd0 || acq_perm_o !== NTOT) begin err_cnt++; $display("FAIL single_acq src/perm got %0d/%0d exp 0/1", acq_source_o, acq_perm_o); end
      acq_ready_i = 1'b1;
      tick();
      acq_ready_i = 1'b0;
      vec_cnt++; if (acq_valid_o !== 1'b0) begin err_cnt++; $display("FAIL single_acq_drop got %b exp 0", acq_valid_o); end
      for (int k = 0; k < 8; k++) begin
         exp_line[k*64 +: 64] = beat_of(1, k);
         if (k == 7) begin
            vec_cnt++; if (ack_valid_o !== 1'b0) begin err_cnt++; $display("FAIL single_ack_early got %b exp 0", ack_valid_o); end
         end
         send_beat(4'd0, (k == 0) ? 4'd5 : 4'd9, beat_of(1, k));
      end
      vec_cnt++; if (ack_valid_o !== 1'b1 || ack_sink_o !== 4'd5) begin err_cnt++; $display("FAIL single_ack valid/sink got %b/%0d exp 1/5", ack_valid_o, ack_sink_o); end
      vec_cnt++; if (refill_valid_o !== 1'b0) begin err_cnt++; $display("FAIL single_refill_early got %b exp 0", refill_valid_o); end
      ack_ready_i = 1'b1;
      tick();
      ack_ready_i = 1'b0;
      vec_cnt++; if (ack_valid_o !== 1'b0 || refill_valid_o !== 1'b1) begin err_cnt++; $display("FAIL single_ack_to_refill ack/refill got %b/%b exp 0/1", ack_valid_o, refill_valid_o); end
      vec_cnt++; if (refill_id_o !== 2'd0 || refill_addr_o !== 64'h1000) begin err_cnt++; $display("FAIL single_refill id/addr got %0d/%h exp 0/1000", refill_id_o, refill_addr_o); end
      vec_cnt++; if (refill_data_o !== exp_line) begin err_cnt++; $display("FAIL single_refill_data got %h exp %h", refill_data_o, exp_line); end
      refill_ready_i = 1'b1;
      tick();
      refill_ready_i = 1'b0;
      vec_cnt++; if (refill_valid_o !== 1'b0 || full_o !== 1'b0) begin err_cnt++; $display("FAIL single_idle refill/full got %b/%b exp 0/0", refill_valid_o, full_o); end
   endtask

   task automatic test_merge();
      logic ack, mg;
      logic [1:0] id;
      req(64'h2000, NTOB, ack, id, mg);
      vec_cnt++; if ({ack, id, mg} !== {1'b1, 2'd0, 1'b0}) begin err_cnt++; $display("FAIL merge_first got %b/%0d/%b exp 1/0/0", ack, id, mg); end
      acq_ready_i = 1'b1;
      tick();
      acq_ready_i = 1'b0;
      send_beat(4'd0, 4'd2, beat_of(2, 0));
      send_beat(4'd0, 4'd2, beat_of(2, 1));
      req(64'h2008, NTOB, ack, id, mg);
      vec_cnt++; if ({ack, id, mg} !== {1'b1, 2'd0, 1'b1}) begin err_cnt++; $display("FAIL merge_second got %b/%0d/%b exp 1/0/1", ack, id, mg); end
      req(64'h2030, NTOT, ack, id, mg);
      vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL merge_perm_upgrade ack got %b exp 0", ack); end
      vec_cnt++; if (acq_valid_o !== 1'b0) begin err_cnt++; $display("FAIL merge_single_acquire acq_valid got %b exp 0", acq_valid_o); end
      for (int k = 2; k < 8; k++) send_beat(4'd0, 4'd2, beat_of(2, k));
      ack_ready_i = 1'b1;
      tick();
      ack_ready_i = 1'b0;
      refill_ready_i = 1'b1;
      req(64'h2000, NTOB, ack, id, mg);
      refill_ready_i = 1'b0;
      vec_cnt++; if ({ack, id, mg} !== {1'b1, 2'd0, 1'b1}) begin err_cnt++; $display("FAIL merge_during_refill got %b/%0d/%b exp 1/0/1", ack, id, mg); end
      vec_cnt++; if (acq_valid_o !== 1'b0 || full_o !== 1'b0) begin err_cnt++; $display("FAIL merge_after_refill acq/full got %b/%b exp 0/0", acq_valid_o, full_o); end
   endtask

   task automatic test_full();
      logic ack, mg;
      logic [1:0] id;
      for (int j = 0; j < 4; j++) begin
         req(64'h3000 + 64'(j) * 64'h40, NTOT, ack, id, mg);
         vec_cnt++; if ({ack, id, mg} !== {1'b1, 2'(j), 1'b0}) begin err_cnt++; $display("FAIL full_alloc%0d got %b/%0d/%b exp 1/%0d/0", j, ack, id, mg, j); end
      end
      vec_cnt++; if (full_o !== 1'b1) begin err_cnt++; $display("FAIL full_flag got %b exp 1", full_o); end
      req(64'h3100, NTOT, ack, id, mg);
      vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL full_fifth_ack got %b exp 0", ack); end
      acq_ready_i = 1'b1;
      for (int j = 0; j < 4; j++) begin
         vec_cnt++; if (acq_valid_o !== 1'b1 || acq_source_o !== 4'(j)) begin err_cnt++; $display("FAIL full_acq_order%0d got %b/%0d exp 1/%0d", j, acq_valid_o, acq_source_o, j); end
         tick();
      end
      acq_ready_i = 1'b0;
      for (int k = 0; k < 8; k++) send_beat(4'd2, 4'd6, beat_of(6, k));
      ack_ready_i = 1'b1;
      tick();
      ack_ready_i = 1'b0;
      refill_ready_i = 1'b1;
      req(64'h3100, NTOT, ack, id, mg);
      refill_ready_i = 1'b0;
      vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL full_no_bypass ack got %b exp 0", ack); end
      req(64'h3100, NTOT, ack, id, mg);
      vec_cnt++; if ({ack, id, mg} !== {1'b1, 2'd2, 1'b0}) begin err_cnt++; $display("FAIL full_freed_alloc got %b/%0d/%b exp 1/2/0", ack, id, mg); end
   endtask

   task automatic test_interleave();
      logic ack, mg;
      logic [1:0] id;
      logic [511:0] line0, line1;
      do_reset();
      req(64'h4000, NTOT, ack, id, mg);
      vec_cnt++; if ({ack, id} !== {1'b1, 2'd0}) begin err_cnt++; $display("FAIL ilv_alloc0 got %b/%0d exp 1/0", ack, id); end
      req(64'h4040, NTOB, ack, id, mg);
      vec_cnt++; if ({ack, id} !== {1'b1, 2'd1}) begin err_cnt++; $display("FAIL ilv_alloc1 got %b/%0d exp 1/1", ack, id); end
      acq_ready_i = 1'b1;
      vec_cnt++; if (acq_source_o !== 4'd0) begin err_cnt++; $display("FAIL ilv_acq0 got %0d exp 0", acq_source_o); end
      tick();
      vec_cnt++; if (acq_source_o !== 4'd1 || acq_addr_o !== 64'h4040) begin err_cnt++; $display("FAIL ilv_acq1 got %0d/%h exp 1/4040", acq_source_o, acq_addr_o); end
      tick();
      acq_ready_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         line0[k*64 +: 64] = beat_of(4, k);
         line1[k*64 +: 64] = beat_of(5, k);
         send_beat(4'd0, 4'd3, beat_of(4, k));
         send_beat(4'd1, 4'd6, beat_of(5, k));
      end
      vec_cnt++; if (ack_valid_o !== 1'b1 || ack_sink_o !== 4'd3) begin err_cnt++; $display("FAIL ilv_ack0 got %b/%0d exp 1/3", ack_valid_o, ack_sink_o); end
      ack_ready_i = 1'b1;
      tick();
      vec_cnt++; if (ack_sink_o !== 4'd6) begin err_cnt++; $display("FAIL ilv_ack1 sink got %0d exp 6", ack_sink_o); end
      tick();
      ack_ready_i = 1'b0;
      vec_cnt++; if (refill_id_o !== 2'd0 || refill_data_o !== line0) begin err_cnt++; $display("FAIL ilv_refill0 id %0d data %h exp 0 %h", refill_id_o, refill_data_o, line0); end
      refill_ready_i = 1'b1;
      tick();
      vec_cnt++; if (refill_id_o !== 2'd1 || refill_data_o !== line1) begin err_cnt++; $display("FAIL ilv_refill1 id %0d data %h exp 1 %h", refill_id_o, refill_data_o, line1); end
      tick();
      refill_ready_i = 1'b0;
      vec_cnt++; if (refill_valid_o !== 1'b0 || full_o !== 1'b0) begin err_cnt++; $display("FAIL ilv_idle refill/full got %b/%b exp 0/0", refill_valid_o, full_o); end
   endtask

   task automatic test_back_to_back();
      logic ack, mg;
      logic [1:0] id;
      do_reset();
      for (int j = 0; j < 4; j++) req(64'h7000 + 64'(j) * 64'h40, NTOT, ack, id, mg);
      for (int c = 0; c < 5; c++) begin
         vec_cnt++; if (acq_valid_o !== 1'b1 || acq_source_o !== 4'd0 || acq_addr_o !== 64'h7000) begin err_cnt++; $display("FAIL bp_acq_hold%0d got %b/%0d/%h exp 1/0/7000", c, acq_valid_o, acq_source_o, acq_addr_o); end
         tick();
      end
      acq_ready_i = 1'b1;
      for (int j = 0; j < 4; j++) begin
         vec_cnt++; if (acq_source_o !== 4'(j)) begin err_cnt++; $display("FAIL bp_rr%0d got %0d exp %0d", j, acq_source_o, j); end
         tick();
      end
      acq_ready_i = 1'b0;
      vec_cnt++; if (acq_valid_o !== 1'b0) begin err_cnt++; $display("FAIL bp_acq_done got %b exp 0", acq_valid_o); end
      for (int k = 0; k < 8; k++) send_beat(4'd3, 4'hB, beat_of(7, k));
      for (int k = 0; k < 8; k++) begin
         vec_cnt++; if (ack_valid_o !== 1'b1 || ack_sink_o !== 4'hB) begin err_cnt++; $display("FAIL bp_ack_hold%0d got %b/%0d exp 1/11", k, ack_valid_o, ack_sink_o); end
         send_beat(4'd1, 4'hD, beat_of(8, k));
      end
      vec_cnt++; if (ack_sink_o !== 4'hB) begin err_cnt++; $display("FAIL bp_ack_locked got %0d exp 11", ack_sink_o); end
      ack_ready_i = 1'b1;
      tick();
      vec_cnt++; if (ack_sink_o !== 4'hD || refill_id_o !== 2'd3) begin err_cnt++; $display("FAIL bp_ack_next sink/refill got %0d/%0d exp 13/3", ack_sink_o, refill_id_o); end
      tick();
      ack_ready_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         vec_cnt++; if (refill_valid_o !== 1'b1 || refill_id_o !== 2'd3 || refill_addr_o !== 64'h70C0) begin err_cnt++; $display("FAIL bp_refill_hold%0d got %b/%0d/%h exp 1/3/70c0", c, refill_valid_o, refill_id_o, refill_addr_o); end
         tick();
      end
      refill_ready_i = 1'b1;
      tick();
      vec_cnt++; if (refill_id_o !== 2'd1 || refill_addr_o !== 64'h7040) begin err_cnt++; $display("FAIL bp_refill_next got %0d/%h exp 1/7040", refill_id_o, refill_addr_o); end
      tick();
      refill_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic ack, mg;
      logic [1:0] id;
      do_reset();
      req(64'h5000, NTOT, ack, id, mg);
      acq_ready_i = 1'b1;
      tick();
      acq_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) send_beat(4'd0, 4'd4, beat_of(9, k));
      do_reset();
      vec_cnt++; if (acq_valid_o !== 1'b0 || ack_valid_o !== 1'b0 || refill_valid_o !== 1'b0) begin err_cnt++; $display("FAIL rstmid_valids got %b%b%b exp 000", acq_valid_o, ack_valid_o, refill_valid_o); end
      vec_cnt++; if (full_o !== 1'b0 || refill_data_o !== '0 || acq_addr_o !== '0) begin err_cnt++; $display("FAIL rstmid_payload full %b addr %h", full_o, acq_addr_o); end
      req(64'h6000, NTOT, ack, id, mg);
      vec_cnt++; if ({ack, id, mg} !== {1'b1, 2'd0, 1'b0}) begin err_cnt++; $display("FAIL rstmid_alloc got %b/%0d/%b exp 1/0/0", ack, id, mg); end
      vec_cnt++; if (acq_valid_o !== 1'b1 || acq_addr_o !== 64'h6000) begin err_cnt++; $display("FAIL rstmid_acq got %b/%h exp 1/6000", acq_valid_o, acq_addr_o); end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single_miss();
      test_merge();
      test_full();
      test_interleave();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/sy_dcache_mshr_file.md
# sy_dcache_mshr_file

Parametrised, non-blocking miss-status holding register file for the data cache; replaces the single-outstanding-miss path between the dcache controller and the TileLink port. It tracks up to NUM_MSHR outstanding line misses, merges secondary misses to a line already in flight, and issues AcquireBlock on A. It collects multi-beat GrantData on D, returns GrantAck on E, then hands the assembled line to the controller for refill.

## Interface
- NUM_MSHR, 4: outstanding line misses (power of two, ≥2)
- ADDR_WTH, 64: physical address width
- LINE_BYTES, 64: cache line size
- BEAT_BYTES, 8: TileLink data beat size; BEATS = LINE_BYTES/BEAT_BYTES
- SRC_BASE, 0: first A-channel source id; entry i uses SRC_BASE+i
- SRC_WTH, 4 / SINK_WTH, 4: source/sink id widths
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset is synchronous and active-high
- miss_req_i  in  1  controller miss request
- miss_addr_i  in  ADDR_WTH  miss address; low log2(LINE_BYTES) bits ignored
- miss_perm_i  in  3  TileLink grow param (NtoB/NtoT/BtoT)
- miss_ack_o  out  1  request accepted (allocated or merged)
- miss_id_o  out  log2(NUM_MSHR)  entry index holding the line
- miss_merge_o  out  1  request merged into existing entry
- full_o  out  1  no free entry
- acq_valid_o / acq_ready_i  out/in  1  A-channel AcquireBlock handshake
- acq_addr_o  out  ADDR_WTH  line-aligned address
- acq_perm_o  out  3  grow param
- acq_source_o  out  SRC_WTH  source id
- gnt_valid_i / gnt_ready_o  in/out  1  D-channel GrantData handshake
- gnt_source_i  in  SRC_WTH;  gnt_sink_i  in  SINK_WTH;  gnt_data_i  in  BEAT_BYTES*8
- ack_valid_o / ack_ready_i  out/in  1  E-channel GrantAck handshake
- ack_sink_o  out  SINK_WTH  sink id captured from grant
- refill_valid_o / refill_ready_i  out/in  1  refill handshake to controller
- refill_id_o  out  log2(NUM_MSHR);  refill_addr_o  out  ADDR_WTH;  refill_data_o  out  LINE_BYTES*8

## Operation
- Per-entry FSM: IDLE → ACQ (acq_valid) → GNT (collect beats) → ACK (ack_valid) → REFILL (refill_valid) → IDLE.
- Allocation: if miss_req_i and line matches any non-IDLE entry: miss_ack_o=1, miss_merge_o=1, miss_id_o=matching index, no state change. Else if a free entry exists: lowest free index allocated, miss_ack_o=1, miss_merge_o=0. Else miss_ack_o=0.
- Merge compares line address only; perm upgrade on merge is not supported: a merge whose miss_perm_i needs more than the entry's perm is not acked until that entry frees.
- A arbitration: round-robin among ACQ entries; pointer advances past winner on fire.
- D: gnt_ready_o=1 always. Beat routed by gnt_source_i−SRC_BASE. Beats arrive in ascending order; a per-entry beat counter writes beat k to bits [k*BEAT_BYTES*8 +: BEAT_BYTES*8]. Sink is captured on the first beat. Last beat (counter==BEATS−1) moves the entry to ACK.
- E and refill arbitration: fixed priority, lowest index first.
- Unknown source, or a beat to a non-GNT entry: simulation assertion; beat dropped.
- full_o=1 iff all entries non-IDLE.

## Timing
- Reset: all entries IDLE, counters 0, RR pointer 0; every valid/ack output 0, full_o 0, data/id outputs 0.
- miss_ack_o, miss_id_o, miss_merge_o are combinational in the request cycle.
- acq_valid_o is registered and asserts the cycle after allocation at the earliest.
- Entry leaves ACK the cycle after ack fire; refill_valid_o asserts that cycle. Entry returns to IDLE on refill fire.
- Freed entry is allocatable the next cycle; there is no same-cycle free→alloc bypass. A request matching an entry that is in REFILL with refill firing that cycle merges; the controller re-looks up.
- Ready-low stalls hold all valid outputs and payloads stable.
- rst_i mid-transaction discards all entries with no drain. The caller quiesces the bus first.

## Structure
- sy_pkg gains mshr_state_e (IDLE, ACQ, GNT, ACK, REFILL) and the per-entry record mshr_entry_t (addr, perm, sink, beat count, line buffer).
- Sub-module sy_dcache_mshr_entry holds one FSM, beat counter and line buffer. The top holds the match/allocate logic and the A/E/refill arbiters.

## Test plan
- Single miss, BEATS=8: req 0x1000 → ack id0, merge0; acq addr 0x1000 source 0; 8 beats → GrantAck with captured sink; refill data equals concatenated beats; entry IDLE.
- Secondary merge: req 0x1000 then 0x1008 while in GNT → second ack merge1 id0; only one Acquire issued.
- Full: 4 distinct lines outstanding → full_o=1, 5th request not acked; after one refill fires, 5th acked next cycle into freed index.
- Interleaved grants: sources 0 and 1 alternate beats → both lines assembled correctly; refill order id0 then id1 if both ready.
- Back-pressure: acq_ready_i, ack_ready_i, refill_ready_i held low 5 cycles → outputs stable; RR grants entries 0,1,2,3 in turn.
- Reset in GNT after 3 beats → all outputs 0 next cycle; new miss then allocates id0.
